id_ex_stage: RTL and testbench

//   ID/EX pipeline register feeding the ALU. Captures decoded operands and

---
 rtl/id_ex_stage.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register in front of the ALU.
//   Holds one decoded instruction (valid bit only, no skid buffer) and resolves
//   EX/MEM and MEM/WB forwarding combinationally on the held source indices.
//   A load in the stage whose rd is read by the incoming instruction blocks
//   capture for one cycle. The load leaves and a bubble follows it. Every
//   hazard cycle is counted in a saturating stall counter.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid / in_ready           decode-side handshake
//   in_rs1_addr .. in_mem_read    decoded operands and control
//   flush                         squash the held and the incoming instruction
//   exmem_* / memwb_*             forwarding sources from later stages
//   out_valid / out_ready         EX-side handshake
//   operand1, operand2, alu_op    to the ALU
//   out_rd_addr, out_reg_write,
//   out_mem_read                  registered control for later stages
//   stall_cnt                     saturating count of load-use stall cycles
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned OP_W  = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rs1_addr,
  input  logic [RA_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [OP_W-1:0] in_alu_op,
  input  logic [RA_W-1:0] in_rd_addr,
  input  logic            in_reg_write,
  input  logic            in_mem_read,
  input  logic            flush,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic            exmem_wr,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic            memwb_wr,
  input  logic [XLEN-1:0] memwb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [OP_W-1:0] alu_op,
  output logic [RA_W-1:0] out_rd_addr,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic [CNT_W-1:0] stall_cnt
);

  logic            valid_q, valid_d;
  logic [RA_W-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic            use_imm_q, reg_write_q, mem_read_q;
  logic [OP_W-1:0] alu_op_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic hazard;
  logic capture;

  // EX/MEM has priority over MEM/WB; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] held,
    input logic [RA_W-1:0] ex_rd,
    input logic            ex_wr,
    input logic [XLEN-1:0] ex_res,
    input logic [RA_W-1:0] wb_rd,
    input logic            wb_wr,
    input logic [XLEN-1:0] wb_res
  );
    logic [XLEN-1:0] r;
    r = held;
    if (ex_wr && (ex_rd != '0) && (ex_rd == rs)) begin
      r = ex_res;
    end else if (wb_wr && (wb_rd != '0) && (wb_rd == rs)) begin
      r = wb_res;
    end
    return r;
  endfunction

  always_comb begin
    hazard = valid_q && mem_read_q && (rd_addr_q != '0) && in_valid &&
             ((in_rs1_addr == rd_addr_q) || (!in_use_imm && (in_rs2_addr == rd_addr_q)));
    // During flush decode is always drained; the incoming instruction is dropped.
    in_ready = flush || ((!valid_q || out_ready) && !hazard);
    capture  = in_valid && in_ready && !flush;

    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      alu_op_q    <= '0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (capture) begin
        rs1_addr_q  <= in_rs1_addr;
        rs2_addr_q  <= in_rs2_addr;
        rs1_data_q  <= in_rs1_data;
        rs2_data_q  <= in_rs2_data;
        imm_q       <= in_imm;
        use_imm_q   <= in_use_imm;
        alu_op_q    <= in_alu_op;
        rd_addr_q   <= in_rd_addr;
        reg_write_q <= in_reg_write;
        mem_read_q  <= in_mem_read;
      end
    end
  end

  always_comb begin
    operand1 = fwd(rs1_addr_q, rs1_data_q, exmem_rd, exmem_wr, exmem_result,
                   memwb_rd, memwb_wr, memwb_result);
    operand2 = use_imm_q ? imm_q :
               fwd(rs2_addr_q, rs2_data_q, exmem_rd, exmem_wr, exmem_result,
                   memwb_rd, memwb_wr, memwb_result);
  end

  assign out_valid     = valid_q;
  assign alu_op        = alu_op_q;
  assign out_rd_addr   = rd_addr_q;
  assign out_reg_write = reg_write_q;
  assign out_mem_read  = mem_read_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm, in_reg_write, in_mem_read;
  logic [2:0]  in_alu_op;
  logic        flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_wr, memwb_wr;
  logic [31:0] exmem_result, memwb_result;
  logic        out_valid, out_ready;
  logic [31:0] operand1, operand2;
  logic [2:0]  alu_op;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write, out_mem_read;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1_addr  (in_rs1_addr),
    .in_rs2_addr  (in_rs2_addr),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .in_imm       (in_imm),
    .in_use_imm   (in_use_imm),
    .in_alu_op    (in_alu_op),
    .in_rd_addr   (in_rd_addr),
    .in_reg_write (in_reg_write),
    .in_mem_read  (in_mem_read),
    .flush        (flush),
    .exmem_rd     (exmem_rd),
    .exmem_wr     (exmem_wr),
    .exmem_result (exmem_result),
    .memwb_rd     (memwb_rd),
    .memwb_wr     (memwb_wr),
    .memwb_result (memwb_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .operand1     (operand1),
    .operand2     (operand2),
    .alu_op       (alu_op),
    .out_rd_addr  (out_rd_addr),
    .out_reg_write(out_reg_write),
    .out_mem_read (out_mem_read),
    .stall_cnt    (stall_cnt)
  );

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic        use_imm;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  exrd;
    logic        exwr;
    logic [31:0] exres;
    logic [4:0]  wbrd;
    logic        wbwr;
    logic [31:0] wbres;
    logic [31:0] e1, e2;
  } vec_t;

  typedef struct {
    logic [31:0] e1, e2;
    logic [2:0]  op;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] imm, input logic use_imm,
                       input logic [2:0] op, input logic [4:0] rd, input logic mr);
    in_valid     = 1'b1;
    in_rs1_addr  = rs1;
    in_rs2_addr  = rs2;
    in_rs1_data  = d1;
    in_rs2_data  = d2;
    in_imm       = imm;
    in_use_imm   = use_imm;
    in_alu_op    = op;
    in_rd_addr   = rd;
    in_reg_write = 1'b1;
    in_mem_read  = mr;
  endtask

  task automatic set_fwd(input logic [4:0] exrd, input logic exwr, input logic [31:0] exres,
                         input logic [4:0] wbrd, input logic wbwr, input logic [31:0] wbres);
    exmem_rd     = exrd;
    exmem_wr     = exwr;
    exmem_result = exres;
    memwb_rd     = wbrd;
    memwb_wr     = wbwr;
    memwb_result = wbres;
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty got out_valid=%0d want queued entry", name, out_valid);
    end else begin
      checks--;
      e = sb.pop_front();
      chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, ".op1"}, operand1, e.e1);
      chk({name, ".op2"}, operand2, e.e2);
      chk({name, ".aluop"}, {29'd0, alu_op}, {29'd0, e.op});
      chk({name, ".rd"}, {27'd0, out_rd_addr}, {27'd0, e.rd});
    end
  endtask

  initial begin
    // rs1 rs2 d1 d2 imm use_imm op rd | exmem | memwb | expected op1 op2
    vecs[0] = '{5'd1, 5'd2, 32'd5, 32'd9, 32'd7, 1'b1, 3'd0, 5'd10,
                5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd5, 32'd7};
    vecs[1] = '{5'd3, 5'd2, 32'h33, 32'h22, 32'd0, 1'b0, 3'd1, 5'd11,
                5'd3, 1'b1, 32'hA, 5'd3, 1'b1, 32'hB, 32'hA, 32'h22};
    vecs[2] = '{5'd3, 5'd2, 32'h33, 32'h22, 32'd0, 1'b0, 3'd2, 5'd12,
                5'd3, 1'b0, 32'hA, 5'd3, 1'b1, 32'hB, 32'hB, 32'h22};
    vecs[3] = '{5'd0, 5'd0, 32'h77, 32'h66, 32'd0, 1'b0, 3'd3, 5'd13,
                5'd0, 1'b1, 32'hA, 5'd0, 1'b1, 32'hB, 32'h77, 32'h66};
    vecs[4] = '{5'd6, 5'd7, 32'd1, 32'd2, 32'd0, 1'b0, 3'd4, 5'd14,
                5'd7, 1'b1, 32'h00C0FFEE, 5'd6, 1'b1, 32'hBEEF, 32'hBEEF, 32'h00C0FFEE};
    vecs[5] = '{5'd8, 5'd7, 32'h88, 32'd2, 32'hFFFFFFF0, 1'b1, 3'd5, 5'd15,
                5'd7, 1'b1, 32'h1234, 5'd0, 1'b0, 32'd0, 32'h88, 32'hFFFFFFF0};
    vecs[6] = '{5'd9, 5'd10, 32'h99, 32'hAA, 32'd0, 1'b0, 3'd0, 5'd16,
                5'd1, 1'b1, 32'h5, 5'd11, 1'b1, 32'h6, 32'h99, 32'hAA};

    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0);
    in_valid = 1'b0;
    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    #12;
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.operand1", operand1, 32'd0);
    chk("reset.operand2", operand2, 32'd0);
    chk("reset.alu_op", {29'd0, alu_op}, 32'd0);
    chk("reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven capture and forwarding.
    for (int i = 0; i < 7; i++) begin
      exp_t e;
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].d1, vecs[i].d2, vecs[i].imm, vecs[i].use_imm,
            vecs[i].op, vecs[i].rd, 1'b0);
      set_fwd(vecs[i].exrd, vecs[i].exwr, vecs[i].exres, vecs[i].wbrd, vecs[i].wbwr,
              vecs[i].wbres);
      e.e1 = vecs[i].e1;
      e.e2 = vecs[i].e2;
      e.op = vecs[i].op;
      e.rd = vecs[i].rd;
      sb.push_back(e);
      #1 chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      pop_check($sformatf("vec%0d", i));
    end
    @(posedge clk);
    @(negedge clk);
    chk("drain.out_valid", {31'd0, out_valid}, 32'd0);

    // Load-use: lw x4 held, add x5,x4,x1 arrives.
    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    drive(5'd1, 5'd0, 32'h100, 32'd0, 32'd0, 1'b1, 3'd0, 5'd4, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("lu.load_valid", {31'd0, out_valid}, 32'd1);
    chk("lu.load_memrd", {31'd0, out_mem_read}, 32'd1);
    drive(5'd4, 5'd1, 32'h0, 32'h11, 32'd0, 1'b0, 3'd0, 5'd5, 1'b0);
    set_fwd(5'd4, 1'b1, 32'h44, 5'd0, 1'b0, 32'd0);
    sb.push_back('{32'h44, 32'h11, 3'd0, 5'd5});
    #1 chk("lu.in_ready_stall", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lu.bubble", {31'd0, out_valid}, 32'd0);
    chk("lu.stall_cnt", {16'd0, stall_cnt}, 32'd1);
    chk("lu.in_ready_after", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    pop_check("lu.add");
    chk("lu.stall_cnt_once", {16'd0, stall_cnt}, 32'd1);
    @(posedge clk);
    @(negedge clk);

    // Backpressure: A held for 3 cycles while B waits.
    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    drive(5'd2, 5'd0, 32'hAA, 32'd0, 32'd1, 1'b1, 3'd2, 5'd8, 1'b0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    drive(5'd2, 5'd0, 32'hBB, 32'd0, 32'd1, 1'b1, 3'd3, 5'd9, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("bp%0d.in_ready", c), {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp%0d.valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d.op1", c), operand1, 32'hAA);
      chk($sformatf("bp%0d.rd", c), {27'd0, out_rd_addr}, 32'd8);
    end
    out_ready = 1'b1;
    #1 chk("bp.in_ready_release", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp.next_op1", operand1, 32'hBB);
    chk("bp.next_rd", {27'd0, out_rd_addr}, 32'd9);
    chk("bp.next_valid", {31'd0, out_valid}, 32'd1);

    // Flush with B held and C incoming.
    out_ready = 1'b0;
    drive(5'd2, 5'd0, 32'hCC, 32'd0, 32'd1, 1'b1, 3'd0, 5'd10, 1'b0);
    flush = 1'b1;
    #1 chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush.valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("flush.dropped", {31'd0, out_valid}, 32'd0);

    // Saturation: a held load with a stalled consumer keeps hazard high.
    out_ready = 1'b1;
    drive(5'd1, 5'd0, 32'h123, 32'd0, 32'd0, 1'b1, 3'd0, 5'd4, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("sat.load_op1", operand1, 32'h123);
    out_ready = 1'b0;
    drive(5'd4, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 3'd0, 5'd6, 1'b0);
    #1 chk("sat.in_ready", {31'd0, in_ready}, 32'd0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("sat.cnt_101", {16'd0, stall_cnt}, 32'd101);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("sat.cnt_max", {16'd0, stall_cnt}, 32'h0000FFFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat.cnt_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("sat.valid_held", {31'd0, out_valid}, 32'd1);

    // Asynchronous reset mid-cycle with a valid entry.
    #2 rst_n = 1'b0;
    #1;
    chk("areset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("areset.operand1", operand1, 32'd0);
    chk("areset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("areset.alu_op", {29'd0, alu_op}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
